multicycle_datapath: RTL

Multicycle RISC-V datapath driven directly by the microprogrammed `controller`. It consumes the controller's mux-select, ALU and write-enable outputs, and returns `op`, `funct3`, `funct7b5` and `Zero` to the controller. It holds PC, IR, the non-architectural registers and the 32×32 register file, and interfaces to a single unified instruction/data memory.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/multicycle_datapath_regfile.sv | 27 ++
 rtl/multicycle_datapath.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller and datapath:
// opcodes, ALU operations and the mux-select codes driven by the controller.
package riscv_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_ITYPE  = 7'b0010011,
      OP_STORE  = 7'b0100011,
      OP_RTYPE  = 7'b0110011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111
   } opcodetype;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   localparam logic [1:0] SRCB_ZERO = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_ZERO      = 2'b11;

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; x0 reads as zero and ignores writes. Contents are not reset.
module regfile
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk) begin
      if (we && (wa != 5'd0)) begin
         regs_q[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RISC-V datapath steered by the microprogrammed controller.
// Build option: DATAPATH_SLT_EN enables the signed slt ALU operation.
module multicycle_datapath
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  ImmSrc,
   input  logic [1:0]  ALUSrcA,
   input  logic [1:0]  ALUSrcB,
   input  logic [1:0]  ResultSrc,
   input  logic        AdrSrc,
   input  logic [2:0]  ALUControl,
   input  logic        IRWrite,
   input  logic        PCWrite,
   input  logic        RegWrite,
   input  logic [31:0] ReadData,
   output logic [31:0] Adr,
   output logic [31:0] WriteData,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct7b5,
   output logic        Zero
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] old_pc_q, old_pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] data_q, data_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_out_q, alu_out_d;

   logic [31:0] rd1, rd2;
   logic [31:0] imm_ext;
   logic [31:0] src_a, src_b;
   logic [31:0] alu_result;
   logic [31:0] result;

   // Writes are gated during reset so a held reset cannot disturb x1..x31.
   regfile u_regfile (
      .clk (clk),
      .we  (RegWrite & ~reset),
      .ra1 (ir_q[19:15]),
      .ra2 (ir_q[24:20]),
      .wa  (ir_q[11:7]),
      .wd  (result),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_comb begin
      imm_ext = 32'd0;
      case (ImmSrc)
         IMM_I: imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
         IMM_S: imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         IMM_B: imm_ext = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
         IMM_J: imm_ext = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
         default: imm_ext = 32'd0;
      endcase
   end

   always_comb begin
      src_a = 32'd0;
      case (ALUSrcA)
         SRCA_PC:    src_a = pc_q;
         SRCA_OLDPC: src_a = old_pc_q;
         SRCA_A:     src_a = a_q;
         default:    src_a = 32'd0;
      endcase
      src_b = 32'd0;
      case (ALUSrcB)
         SRCB_B:    src_b = b_q;
         SRCB_IMM:  src_b = imm_ext;
         SRCB_FOUR: src_b = 32'd4;
         default:   src_b = 32'd0;
      endcase
   end

   always_comb begin
      alu_result = 32'd0;
      case (ALUControl)
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
`ifdef DATAPATH_SLT_EN
         ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
`endif
         default: alu_result = 32'd0;
      endcase
   end

   // ResultSrc never selects ReadData directly, which keeps memory out of the
   // combinational path into the register file and PC.
   always_comb begin
      result = 32'd0;
      case (ResultSrc)
         RES_ALUOUT:    result = alu_out_q;
         RES_DATA:      result = data_q;
         RES_ALURESULT: result = alu_result;
         default:       result = 32'd0;
      endcase
   end

   always_comb begin
      pc_d      = PCWrite ? result : pc_q;
      ir_d      = IRWrite ? ReadData : ir_q;
      old_pc_d  = IRWrite ? pc_q : old_pc_q;
      data_d    = ReadData;
      a_d       = rd1;
      b_d       = rd2;
      alu_out_d = alu_result;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         old_pc_q  <= 32'd0;
         ir_q      <= 32'd0;
         data_q    <= 32'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         alu_out_q <= 32'd0;
      end else begin
         pc_q      <= pc_d;
         old_pc_q  <= old_pc_d;
         ir_q      <= ir_d;
         data_q    <= data_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
      end
   end

   // The address is pinned to the reset vector while reset is held, whatever AdrSrc says.
   assign Adr       = reset ? RESET_PC : (AdrSrc ? result : pc_q);
   assign WriteData = b_q;
   assign op        = ir_q[6:0];
   assign funct3    = ir_q[14:12];
   assign funct7b5  = ir_q[30];
   assign Zero      = (alu_result == 32'd0);

endmodule
